// File: rtl/systolic_ctrl_if.sv
// Handshake bundle between the systolic controller and its host side.
//   in_valid/in_ready/in_data    : input beat stream (weights, biases, samples)
//   res_valid/res_ready/res_data : drained accumulator results
//   res_idx                      : PE index carried with each result
// master = host/loader side, slave = controller side.
interface systolic_ctrl_if #(
  parameter int DW = 4,
  parameter int AW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          res_valid;
  logic          res_ready;
  logic [AW-1:0] res_data;
  logic [1:0]    res_idx;

  modport master (
    output in_valid, in_data, res_ready,
    input  in_ready, res_valid, res_data, res_idx
  );

  modport slave (
    input  in_valid, in_data, res_ready,
    output in_ready, res_valid, res_data, res_idx
  );
endinterface

// File: rtl/systolic_ctrl.sv
// Sequencer for a 4-PE linear systolic array.
// A single input stream carries 4 weights, 4 biases and N samples; the
// controller turns them into per-PE load strobes and a skewed accumulate
// enable, waits for the last sample to reach the final PE, then drains the
// four accumulators through a valid/ready result port.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   start, num_samples    : job launch (sampled in IDLE) and sample count N
//   busy, done            : job status, done is a one-cycle pulse
//   bus (slave)           : input beat stream and result stream
//   arr_*_in              : data/weight/bias buses into the array
//   pe_weight_en/bias_en  : one-hot load strobes, one cycle after the beat
//   pe_acc_en             : per-PE accumulate enable (valid pipe)
//   drain_sel/arr_acc_out : array accumulator select and its muxed output
module systolic_ctrl #(
  parameter int NUM_PE = 4,
  parameter int DW     = 4,
  parameter int AW     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        num_samples,
  output logic              busy,
  output logic              done,
  systolic_ctrl_if.slave    bus,
  output logic [DW-1:0]     arr_data_in,
  output logic [DW-1:0]     arr_weight_in,
  output logic [DW-1:0]     arr_bias_in,
  output logic [NUM_PE-1:0] pe_weight_en,
  output logic [NUM_PE-1:0] pe_bias_en,
  output logic [NUM_PE-1:0] pe_acc_en,
  output logic [1:0]        drain_sel,
  input  logic [AW-1:0]     arr_acc_out
);

  typedef enum logic [2:0] {
    IDLE, LOAD_W, LOAD_B, STREAM, FLUSH, DRAIN, DONE
  } state_t;

  localparam logic [NUM_PE-1:0] ONE = NUM_PE'(1);

  state_t            state, state_nxt;
  logic [1:0]        k;        // beat index in LOAD_W/LOAD_B, cycle index in FLUSH
  logic [3:0]        num;      // latched N
  logic [3:0]        s_cnt;    // samples accepted so far
  logic [1:0]        res_idx;
  logic [NUM_PE-1:0] vld_pipe;

  logic in_fire, res_fire, stream_fire, k_inc;

  assign in_fire     = bus.in_valid & bus.in_ready;
  assign res_fire    = bus.res_valid & bus.res_ready;
  assign stream_fire = (state == STREAM) & in_fire;
  assign k_inc       = (((state == LOAD_W) || (state == LOAD_B)) && in_fire) ||
                       (state == FLUSH);

  assign pe_acc_en   = vld_pipe;
  assign drain_sel   = res_idx;
  assign bus.res_idx = res_idx;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (start) state_nxt = LOAD_W;
      LOAD_W: if (in_fire && k == 2'd3) state_nxt = LOAD_B;
      LOAD_B: if (in_fire && k == 2'd3) state_nxt = (num == 4'd0) ? FLUSH : STREAM;
      STREAM: if (in_fire && s_cnt == num - 4'd1) state_nxt = FLUSH;
      // Four cycles is exactly the skew for the last sample to reach PE 3.
      FLUSH:  if (k == 2'd3) state_nxt = DRAIN;
      DRAIN:  if (res_fire && res_idx == 2'd3) state_nxt = DONE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // state-decoded outputs; they fall to zero as soon as reset forces IDLE
  always_comb begin
    busy          = (state != IDLE);
    done          = (state == DONE);
    bus.in_ready  = (state == LOAD_W) || (state == LOAD_B) || (state == STREAM);
    bus.res_valid = (state == DRAIN);
    bus.res_data  = (state == DRAIN) ? arr_acc_out : '0;
  end

  // datapath: strobes, valid pipe, counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k             <= '0;
      num           <= '0;
      s_cnt         <= '0;
      res_idx       <= '0;
      vld_pipe      <= '0;
      arr_data_in   <= '0;
      arr_weight_in <= '0;
      arr_bias_in   <= '0;
      pe_weight_en  <= '0;
      pe_bias_en    <= '0;
    end else begin
      // strobes and data are single-cycle unless re-armed by a beat;
      // a bubble shifts a zero into the valid pipe
      pe_weight_en <= '0;
      pe_bias_en   <= '0;
      arr_data_in  <= '0;
      vld_pipe     <= {vld_pipe[NUM_PE-2:0], stream_fire};

      if (state_nxt != state) k <= '0;
      else if (k_inc)         k <= k + 2'd1;

      unique case (state)
        IDLE: if (start) begin
          num     <= num_samples;
          s_cnt   <= '0;
          res_idx <= '0;
        end
        LOAD_W: if (in_fire) begin
          arr_weight_in <= bus.in_data;
          pe_weight_en  <= ONE << k;
        end
        LOAD_B: if (in_fire) begin
          arr_bias_in <= bus.in_data;
          pe_bias_en  <= ONE << k;
        end
        STREAM: if (in_fire) begin
          arr_data_in <= bus.in_data;
          s_cnt       <= s_cnt + 4'd1;
        end
        DRAIN: if (res_fire) res_idx <= res_idx + 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
module tb_systolic_ctrl;
  localparam int NUM_PE = 4;
  localparam int DW     = 4;
  localparam int AW     = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic [3:0]        num_samples = 4'd0;
  logic              busy, done;
  logic [DW-1:0]     arr_data_in, arr_weight_in, arr_bias_in;
  logic [NUM_PE-1:0] pe_weight_en, pe_bias_en, pe_acc_en;
  logic [1:0]        drain_sel;
  logic [AW-1:0]     arr_acc_out;

  int checks = 0;
  int errors = 0;

  systolic_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  systolic_ctrl #(.NUM_PE(NUM_PE), .DW(DW), .AW(AW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .num_samples   (num_samples),
    .busy          (busy),
    .done          (done),
    .bus           (bus),
    .arr_data_in   (arr_data_in),
    .arr_weight_in (arr_weight_in),
    .arr_bias_in   (arr_bias_in),
    .pe_weight_en  (pe_weight_en),
    .pe_bias_en    (pe_bias_en),
    .pe_acc_en     (pe_acc_en),
    .drain_sel     (drain_sel),
    .arr_acc_out   (arr_acc_out)
  );

  // array stand-in: accumulator i reads back as 8'h11*i
  assign arr_acc_out = 8'h11 * {6'b0, drain_sel};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected pe_acc_en in cycle c when the valid bit for PE 0 starts at
  // cycle t0 and msk bit t says whether a sample sits in slot t0+t.
  function automatic int acc_exp(int c, int t0, int msk);
    int r = 0;
    for (int i = 0; i < 4; i++) begin
      int t = c - t0 - i;
      if (t >= 0 && t < 16 && msk[t]) r |= (1 << i);
    end
    return r;
  endfunction

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.res_ready = 1'b0;

    // ---- reset state ----
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ctrl", 32'({busy, done, bus.in_ready, bus.res_valid, bus.res_idx, drain_sel}), 0);
    chk("rst_en",   32'({pe_weight_en, pe_bias_en, pe_acc_en}), 0);
    chk("rst_bus",  32'({arr_data_in, arr_weight_in, arr_bias_in, bus.res_data}), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // ---- test 1: zero-stall N=3, start/num_samples poked mid-job ----
    start = 1'b1; num_samples = 4'd3;
    bus.in_valid = 1'b1; bus.res_ready = 1'b1; bus.in_data = '0;
    for (int c = 1; c <= 21; c++) begin
      int ew, eb;
      tick();
      if (c == 1) start = 1'b0;
      ew = (c >= 2 && c <= 5) ? (1 << (c - 2)) : 0;
      eb = (c >= 6 && c <= 9) ? (1 << (c - 6)) : 0;
      chk("t1_wen", 32'(pe_weight_en), ew);
      if (ew != 0) chk("t1_w", 32'(arr_weight_in), c - 1);
      chk("t1_ben", 32'(pe_bias_en), eb);
      if (eb != 0) chk("t1_b", 32'(arr_bias_in), c - 1);
      chk("t1_acc", 32'(pe_acc_en), acc_exp(c, 10, 7));
      chk("t1_data", 32'(arr_data_in), (c >= 10 && c <= 12) ? c - 1 : 0);
      chk("t1_rdy", 32'(bus.in_ready), (c <= 11) ? 1 : 0);
      chk("t1_busy", 32'(busy), (c <= 20) ? 1 : 0);
      chk("t1_done", 32'(done), (c == 20) ? 1 : 0);
      chk("t1_rvld", 32'(bus.res_valid), (c >= 16 && c <= 19) ? 1 : 0);
      if (c >= 16 && c <= 19) begin
        chk("t1_ridx", 32'(bus.res_idx), c - 16);
        chk("t1_rdat", 32'(bus.res_data), 17 * (c - 16));
      end
      bus.in_data = (c <= 11) ? 4'(c) : 4'd0;
      if (c == 7) begin start = 1'b1; num_samples = 4'd9; end
      if (c == 8) start = 1'b0;
    end

    // ---- test 2: sample gaps, valid pattern 1,0,1,1 ----
    start = 1'b1; num_samples = 4'd3; bus.in_valid = 1'b1; bus.in_data = '0;
    for (int c = 1; c <= 22; c++) begin
      tick();
      if (c == 1) start = 1'b0;
      chk("t2_acc", 32'(pe_acc_en), acc_exp(c, 10, 13));
      if (c >= 9 && c <= 14)
        chk("t2_data", 32'(arr_data_in), (c == 10) ? 3 : (c == 12) ? 5 : (c == 13) ? 6 : 0);
      if (c == 12 || c == 13) chk("t2_rdy", 32'(bus.in_ready), (c == 12) ? 1 : 0);
      chk("t2_done", 32'(done), (c == 21) ? 1 : 0);
      chk("t2_busy", 32'(busy), (c <= 21) ? 1 : 0);
      bus.in_valid = (c != 10);
      case (c)
        9:       bus.in_data = 4'd3;
        10:      bus.in_data = 4'hF;
        11:      bus.in_data = 4'd5;
        12:      bus.in_data = 4'd6;
        default: bus.in_data = (c <= 8) ? 4'(c) : 4'd0;
      endcase
    end

    // ---- test 3: N=0 with drain backpressure at idx 1 ----
    start = 1'b1; num_samples = 4'd0; bus.in_valid = 1'b1; bus.in_data = '0;
    bus.res_ready = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      int ei;
      tick();
      if (c == 1) start = 1'b0;
      ei = (c == 13) ? 0 : (c <= 17) ? 1 : (c == 18) ? 2 : 3;
      chk("t3_acc", 32'(pe_acc_en), 0);
      chk("t3_rdy", 32'(bus.in_ready), (c <= 8) ? 1 : 0);
      chk("t3_rvld", 32'(bus.res_valid), (c >= 13 && c <= 19) ? 1 : 0);
      if (c >= 13 && c <= 19) begin
        chk("t3_ridx", 32'(bus.res_idx), ei);
        chk("t3_sel", 32'(drain_sel), ei);
        chk("t3_rdat", 32'(bus.res_data), 17 * ei);
      end
      chk("t3_done", 32'(done), (c == 20) ? 1 : 0);
      chk("t3_busy", 32'(busy), (c <= 20) ? 1 : 0);
      bus.in_data   = (c <= 8) ? 4'(c) : 4'd0;
      bus.res_ready = !(c >= 14 && c <= 16);
    end

    // ---- test 4: async reset mid-STREAM, then a fresh N=1 job ----
    start = 1'b1; num_samples = 4'd5; bus.in_valid = 1'b1; bus.in_data = '0;
    bus.res_ready = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) start = 1'b0;
      bus.in_data = 4'(c);
    end
    chk("t4_pre_acc", 32'(pe_acc_en), 1);
    chk("t4_pre_data", 32'(arr_data_in), 9);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_rst_ctrl", 32'({busy, done, bus.in_ready, bus.res_valid, bus.res_idx, drain_sel}), 0);
    chk("t4_rst_en",   32'({pe_weight_en, pe_bias_en, pe_acc_en}), 0);
    chk("t4_rst_bus",  32'({arr_data_in, arr_weight_in, arr_bias_in, bus.res_data}), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t4_idle", 32'({busy, bus.in_ready, pe_weight_en}), 0);
    start = 1'b1; num_samples = 4'd1; bus.in_data = '0;
    for (int c = 1; c <= 19; c++) begin
      tick();
      if (c == 1) start = 1'b0;
      chk("t4_acc", 32'(pe_acc_en), acc_exp(c, 10, 1));
      chk("t4_done", 32'(done), (c == 18) ? 1 : 0);
      chk("t4_busy", 32'(busy), (c <= 18) ? 1 : 0);
      chk("t4_rvld", 32'(bus.res_valid), (c >= 14 && c <= 17) ? 1 : 0);
      if (c == 10) chk("t4_data", 32'(arr_data_in), 9);
      bus.in_data = (c <= 9) ? 4'(c) : 4'd0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
